// File: rtl/exp_lut_port_arbiter_pkg.sv
// Shared types and constants for the exponent coefficient LUT datapath.
package exp_lut_pkg;

    localparam int unsigned EXP_Q            = 26;
    localparam int unsigned EXP_W            = 32;
    localparam int unsigned EXP_NUM_SEGMENTS = 8;

    typedef logic [2:0]              seg_idx_t;
    typedef logic signed [EXP_W-1:0] coeff_t;

endpackage

// File: rtl/exp_lut_port_arbiter_if.sv
// EU request/response and LUT port bundle for the exponent LUT port arbiter.
// slave: the arbiter; master: the EU array plus the LUT instance.
interface exp_lut_port_arbiter_if
    import exp_lut_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 32,
    parameter int unsigned NUM_LUT_PORTS = 8,
    parameter int unsigned W             = EXP_W
);

    logic     [NUM_REQ-1:0]                req_valid;
    seg_idx_t [NUM_REQ-1:0]                req_seg;
    logic     [NUM_REQ-1:0]                req_ready;
    seg_idx_t [NUM_LUT_PORTS-1:0]          lut_seg_index;
    logic     [NUM_LUT_PORTS-1:0][W-1:0]   lut_k;
    logic     [NUM_LUT_PORTS-1:0][W-1:0]   lut_b;
    logic     [NUM_REQ-1:0]                rsp_valid;
    logic     [NUM_REQ-1:0][W-1:0]         rsp_k;
    logic     [NUM_REQ-1:0][W-1:0]         rsp_b;

    modport slave (
        input  req_valid, req_seg, lut_k, lut_b,
        output req_ready, lut_seg_index, rsp_valid, rsp_k, rsp_b
    );

    modport master (
        output req_valid, req_seg, lut_k, lut_b,
        input  req_ready, lut_seg_index, rsp_valid, rsp_k, rsp_b
    );

endinterface

// File: rtl/exp_lut_port_arbiter_rr_multi_grant.sv
// Combinational round-robin multi-grant: starting at rr_ptr, grants the first
// NUM_LUT_PORTS asserted requesters in circular order, numbers them with their
// LUT port, and returns the pointer just past the last one granted.
module rr_multi_grant #(
    parameter int unsigned NUM_REQ       = 32,
    parameter int unsigned NUM_LUT_PORTS = 8,
    parameter int unsigned PW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned PORTW         = (NUM_LUT_PORTS > 1) ? $clog2(NUM_LUT_PORTS) : 1
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [PW-1:0]                 rr_ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0][PORTW-1:0] port_num,
    output logic [PW-1:0]                 next_ptr
);

    // Circular scan; "last granted" is last in scan order, so wrap is handled naturally.
    always_comb begin
        int unsigned cnt;
        int unsigned idx;
        grant    = '0;
        port_num = '0;
        next_ptr = rr_ptr;
        cnt      = 0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (req[idx] && (cnt < NUM_LUT_PORTS)) begin
                grant[idx]    = 1'b1;
                port_num[idx] = PORTW'(cnt);
                next_ptr      = PW'((idx + 1) % NUM_REQ);
                cnt           = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/exp_lut_port_arbiter.sv
// Exponent LUT port arbiter: shares NUM_LUT_PORTS LUT ports among NUM_REQ EUs,
// round-robin, with a registered one-cycle coefficient response.
// Optional statistics counters: define EXP_LUT_ARB_STATS_EN.
module exp_lut_port_arbiter
    import exp_lut_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 32,
    parameter int unsigned NUM_LUT_PORTS = 8,
    parameter int unsigned W             = $bits(coeff_t),
    parameter int unsigned Q             = EXP_Q
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef EXP_LUT_ARB_STATS_EN
    output logic [31:0]             stat_stall_cycles,
    output logic [31:0]             stat_grants,
`endif
    exp_lut_port_arbiter_if.slave   bus
);

    localparam int unsigned PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PORTW = (NUM_LUT_PORTS > 1) ? $clog2(NUM_LUT_PORTS) : 1;

    generate
        if ((Q >= W) || (NUM_LUT_PORTS == 0) || (NUM_LUT_PORTS > NUM_REQ)) begin : g_bad_cfg
            $error("exp_lut_port_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [PW-1:0]                 rr_ptr;
    logic [PW-1:0]                 next_ptr;
    logic [NUM_REQ-1:0]            req_eff;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0][PORTW-1:0] port_num;

    // Requests are masked during reset so no grant or LUT routing happens.
    assign req_eff       = rst ? '0 : bus.req_valid;
    assign bus.req_ready = grant;

    rr_multi_grant #(
        .NUM_REQ       (NUM_REQ),
        .NUM_LUT_PORTS (NUM_LUT_PORTS),
        .PW            (PW),
        .PORTW         (PORTW)
    ) u_rr (
        .req      (req_eff),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .port_num (port_num),
        .next_ptr (next_ptr)
    );

    // Route each granted segment index to its LUT port; idle ports drive 0.
    always_comb begin
        bus.lut_seg_index = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                bus.lut_seg_index[port_num[r]] = bus.req_seg[r];
            end
        end
    end

    // Pointer advance and one-cycle registered response; ungranted coefficients hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_k     <= '0;
            bus.rsp_b     <= '0;
        end else begin
            bus.rsp_valid <= grant;
            if (|grant) begin
                rr_ptr <= next_ptr;
            end
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                if (grant[r]) begin
                    bus.rsp_k[r] <= bus.lut_k[port_num[r]];
                    bus.rsp_b[r] <= bus.lut_b[port_num[r]];
                end
            end
        end
    end

`ifdef EXP_LUT_ARB_STATS_EN
    // Stall = some valid requester left ungranted; grants accumulate popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_grants       <= '0;
        end else begin
            if (|(bus.req_valid & ~grant)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
            stat_grants <= stat_grants + 32'($countones(grant));
        end
    end
`endif

endmodule

// File: tb/tb_exp_lut_port_arbiter.sv
// Directed self-checking bench for exp_lut_port_arbiter (32 EUs, 8 LUT ports).
module tb_exp_lut_port_arbiter;
    import exp_lut_pkg::*;

    localparam int unsigned NR = 32;
    localparam int unsigned NP = 8;
    localparam int unsigned W  = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [NR-1:0][W-1:0] exp_k;
    logic [NR-1:0][W-1:0] exp_b;

`ifdef EXP_LUT_ARB_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_grants;
`endif

    exp_lut_port_arbiter_if #(.NUM_REQ(NR), .NUM_LUT_PORTS(NP), .W(W)) bus ();

    exp_lut_port_arbiter #(.NUM_REQ(NR), .NUM_LUT_PORTS(NP), .W(W), .Q(26)) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef EXP_LUT_ARB_STATS_EN
        .stat_stall_cycles (stat_stall_cycles),
        .stat_grants       (stat_grants),
`endif
        .bus               (bus)
    );

    always #5 clk = ~clk;

    // Reference coefficient table (segment 3 is the documented entry).
    function automatic logic [W-1:0] kval(input logic [2:0] s);
        case (s)
            3'd0: kval = 32'h0400_0000;
            3'd1: kval = 32'h03F0_0010;
            3'd2: kval = 32'h03E0_A5A5;
            3'd3: kval = 32'h03C1_8722;
            3'd4: kval = 32'hFC3E_78DE;
            3'd5: kval = 32'h0390_ABCD;
            3'd6: kval = 32'h0370_1234;
            default: kval = 32'h8000_0001;
        endcase
    endfunction

    function automatic logic [W-1:0] bval(input logic [2:0] s);
        case (s)
            3'd0: bval = 32'h0400_0001;
            3'd1: bval = 32'h03FF_F000;
            3'd2: bval = 32'h03F1_1111;
            3'd3: bval = 32'h03C7_6408;
            3'd4: bval = 32'hFFFF_0000;
            3'd5: bval = 32'h03D2_2222;
            3'd6: bval = 32'h03B3_3333;
            default: bval = 32'hF000_0000;
        endcase
    endfunction

    // Combinational LUT model behind the arbiter's ports.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            bus.lut_k[p] = kval(bus.lut_seg_index[p]);
            bus.lut_b[p] = bval(bus.lut_seg_index[p]);
        end
    end

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] grp;

        rst           = 1'b1;
        bus.req_valid = '1;
        for (int r = 0; r < NR; r++) bus.req_seg[r] = 3'(r % 8);
        exp_k = '0;
        exp_b = '0;

        // 1. Reset held two cycles with every requester valid
        #1;
        chk("rst_ready0", bus.req_ready, 0);
        tick();
        chk("rst_ready1", bus.req_ready, 0);
        tick();
        chk("rst_ready2", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_k", bus.rsp_k, 0);
        chk("rst_rsp_b", bus.rsp_b, 0);
        chk("rst_rr_ptr", dut.rr_ptr, 0);

        // 3. All 32 valid; granted EUs drop valid after their transfer
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            grp = 32'hFF << (8 * c);
            #1;
            chk($sformatf("all_ready_c%0d", c), bus.req_ready, grp);
            chk($sformatf("all_lutidx_c%0d", c), bus.lut_seg_index, 24'hFAC688);
            tick();
            for (int r = 0; r < NR; r++) begin
                if (grp[r]) begin
                    exp_k[r] = kval(3'(r % 8));
                    exp_b[r] = bval(3'(r % 8));
                end
            end
            chk($sformatf("all_rsp_valid_c%0d", c), bus.rsp_valid, grp);
            chk($sformatf("all_rsp_k_c%0d", c), bus.rsp_k, exp_k);
            chk($sformatf("all_rsp_b_c%0d", c), bus.rsp_b, exp_b);
            bus.req_valid = bus.req_valid & ~grp;
        end
        chk("all_rr_ptr", dut.rr_ptr, 0);
`ifdef EXP_LUT_ARB_STATS_EN
        // 6. Statistics after the four-cycle burst
        chk("stat_grants", stat_grants, 32);
        chk("stat_stall", stat_stall_cycles, 3);
`endif

        // No valid requests: no grants, idle ports, pointer holds
        #1;
        chk("idle_ready", bus.req_ready, 0);
        chk("idle_lutidx", bus.lut_seg_index, 0);
        tick();
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_rr_ptr", dut.rr_ptr, 0);

        // 2. Single request EU5, segment 3
        bus.req_seg[5] = 3'd3;
        bus.req_valid  = 32'h0000_0020;
        #1;
        chk("single_ready", bus.req_ready, 32'h20);
        chk("single_lutidx", bus.lut_seg_index, 24'h3);
        tick();
        exp_k[5] = 32'h03C1_8722;
        exp_b[5] = 32'h03C7_6408;
        chk("single_rsp_valid", bus.rsp_valid, 32'h20);
        chk("single_rsp_k", bus.rsp_k, exp_k);
        chk("single_rsp_b", bus.rsp_b, exp_b);
        chk("single_rr_ptr", dut.rr_ptr, 6);
        bus.req_valid = '0;
        tick();
        chk("single_pulse", bus.rsp_valid, 0);
        chk("single_hold_k", bus.rsp_k, exp_k);

        // 4. Wrap: move pointer to 28, then request {30,31,0,2}
        bus.req_valid = 32'h0800_0000;
        tick();
        exp_k[27] = kval(3'd3);
        exp_b[27] = bval(3'd3);
        chk("wrap_setup_ptr", dut.rr_ptr, 28);
        bus.req_seg[30] = 3'd1;
        bus.req_seg[31] = 3'd2;
        bus.req_seg[0]  = 3'd4;
        bus.req_seg[2]  = 3'd5;
        bus.req_valid   = 32'hC000_0005;
        #1;
        chk("wrap_ready", bus.req_ready, 32'hC000_0005);
        chk("wrap_lutidx", bus.lut_seg_index, 24'h000B11);
        tick();
        exp_k[30] = kval(3'd1); exp_b[30] = bval(3'd1);
        exp_k[31] = kval(3'd2); exp_b[31] = bval(3'd2);
        exp_k[0]  = kval(3'd4); exp_b[0]  = bval(3'd4);
        exp_k[2]  = kval(3'd5); exp_b[2]  = bval(3'd5);
        chk("wrap_rsp_valid", bus.rsp_valid, 32'hC000_0005);
        chk("wrap_rsp_k", bus.rsp_k, exp_k);
        chk("wrap_rsp_b", bus.rsp_b, exp_b);
        chk("wrap_rr_ptr", dut.rr_ptr, 3);

        // 5. Reset pulsed the cycle after a grant
        bus.req_valid = 32'h0000_0200;
        #1;
        chk("mid_ready", bus.req_ready, 32'h200);
        tick();
        chk("mid_rsp_valid", bus.rsp_valid, 32'h200);
        rst           = 1'b1;
        bus.req_valid = 32'h0000_1000;
        #1;
        chk("mid_rst_ready", bus.req_ready, 0);
        tick();
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_rsp_k", bus.rsp_k, 0);
        chk("mid_rst_rr_ptr", dut.rr_ptr, 0);
        rst             = 1'b0;
        bus.req_seg[12] = 3'd3;
        #1;
        chk("mid_rereq_ready", bus.req_ready, 32'h1000);
        chk("mid_rereq_lutidx", bus.lut_seg_index, 24'h3);
        tick();
        exp_k     = '0;
        exp_b     = '0;
        exp_k[12] = 32'h03C1_8722;
        exp_b[12] = 32'h03C7_6408;
        chk("mid_rereq_rsp_valid", bus.rsp_valid, 32'h1000);
        chk("mid_rereq_rsp_k", bus.rsp_k, exp_k);
        chk("mid_rereq_rsp_b", bus.rsp_b, exp_b);
        chk("mid_rereq_rr_ptr", dut.rr_ptr, 13);
        bus.req_valid = '0;
        tick();
        chk("final_rsp_valid", bus.rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
